// File: rtl/rx_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_tracker
// Description : Groups received bytes into frames using an idle timeout
//               counted in bit times. Each closed frame pushes a record
//               {byte_cnt[11:0], ms[11:0], acc[3:0]} into a first-word
//               fall-through frame-info FIFO, which the host drains.
// Optional    : RX_FRAME_SECOND_STAMP_EN adds second_stamp_i[31:0] and
//               frame_second_o[31:0]. The second stamp is latched with ms/acc
//               and stored with each FIFO entry.
// Ports       : clk, rst (async, active low)
//               p_Enable_i, p_FrameFunctionEnable_i  - both high to run
//               BaudSig_i, p_DataReceived_i          - bit / byte pulses
//               RxTimeOutSet_i                       - idle gap in bit times
//                                                      (0 = never close)
//               acqurate_stamp_i, millisecond_stamp_i - timestamp inputs
//               n_Clr_i                              - sync clear, active low
//               n_rd_frame_fifo_i                    - pop, active low
//               frame_info_o, p_RxFrame_Empty_o, p_RxFrame_Full_o,
//               p_FrameOver_o (sticky drop flag), p_FrameEnd_o (close pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_tracker #(
    parameter int FRAME_DEPTH = 8,
    parameter int PTR_W       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_Enable_i,
    input  logic        p_FrameFunctionEnable_i,
    input  logic        BaudSig_i,
    input  logic        p_DataReceived_i,
    input  logic [15:0] RxTimeOutSet_i,
    input  logic [3:0]  acqurate_stamp_i,
    input  logic [11:0] millisecond_stamp_i,
`ifdef RX_FRAME_SECOND_STAMP_EN
    input  logic [31:0] second_stamp_i,
    output logic [31:0] frame_second_o,
`endif
    input  logic        n_Clr_i,
    input  logic        n_rd_frame_fifo_i,
    output logic [27:0] frame_info_o,
    output logic        p_RxFrame_Empty_o,
    output logic        p_RxFrame_Full_o,
    output logic        p_FrameOver_o,
    output logic        p_FrameEnd_o
);

`ifdef RX_FRAME_SECOND_STAMP_EN
    localparam int c_REC_W = 60;
`else
    localparam int c_REC_W = 28;
`endif
    localparam logic [11:0] c_BYTE_CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RECEIVING = 2'd1,
        CLOSE     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]   idle_cnt_q, idle_cnt_d;
    logic [15:0]   idle_cnt_inc;
    logic [11:0]   ms_q, ms_d;
    logic [3:0]    acc_q, acc_d;
`ifdef RX_FRAME_SECOND_STAMP_EN
    logic [31:0]   sec_q, sec_d;
`endif

    logic          active;
    logic          latch_stamps;
    logic          push_req;

    // Clear also parks the FSM, so it is folded into the run condition.
    assign active = p_Enable_i & p_FrameFunctionEnable_i & n_Clr_i;

    // ------------------------------------------------------------------
    // Frame FSM: next state and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        idle_cnt_inc = idle_cnt_q + 16'd1;
        latch_stamps = 1'b0;
        push_req     = 1'b0;

        if (!active) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            idle_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (p_DataReceived_i) begin
                        state_d      = RECEIVING;
                        byte_cnt_d   = 12'd1;
                        idle_cnt_d   = '0;
                        latch_stamps = 1'b1;
                    end
                end
                RECEIVING: begin
                    // A byte in the same cycle as a baud tick wins: the gap
                    // restarts and the frame cannot close on that tick.
                    if (p_DataReceived_i) begin
                        if (byte_cnt_q != c_BYTE_CNT_MAX) begin
                            byte_cnt_d = byte_cnt_q + 12'd1;
                        end
                        idle_cnt_d   = '0;
                        latch_stamps = 1'b1;
                    end else if (BaudSig_i) begin
                        idle_cnt_d = idle_cnt_inc;
                        if ((RxTimeOutSet_i != 16'd0) && (idle_cnt_inc == RxTimeOutSet_i)) begin
                            state_d = CLOSE;
                        end
                    end
                end
                CLOSE: begin
                    push_req = 1'b1;
                    if (p_DataReceived_i) begin
                        state_d      = RECEIVING;
                        byte_cnt_d   = 12'd1;
                        idle_cnt_d   = '0;
                        latch_stamps = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            endcase
        end
    end

    // Stamps of the most recent byte; the record built in CLOSE uses the
    // registered values, so a byte arriving in CLOSE does not disturb it.
    always_comb begin
        ms_d  = latch_stamps ? millisecond_stamp_i : ms_q;
        acc_d = latch_stamps ? acqurate_stamp_i    : acc_q;
`ifdef RX_FRAME_SECOND_STAMP_EN
        sec_d = latch_stamps ? second_stamp_i      : sec_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            idle_cnt_q <= '0;
            ms_q       <= '0;
            acc_q      <= '0;
`ifdef RX_FRAME_SECOND_STAMP_EN
            sec_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            ms_q       <= ms_d;
            acc_q      <= acc_d;
`ifdef RX_FRAME_SECOND_STAMP_EN
            sec_q      <= sec_d;
`endif
        end
    end

    assign p_FrameEnd_o = push_req;

    // ------------------------------------------------------------------
    // Frame-info FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic                 over_q;
    logic                 fifo_empty, fifo_full;
    logic                 pop_en, push_en, drop;
    logic [c_REC_W-1:0]   rec_in;
    logic [c_REC_W-1:0]   head;
    logic [c_REC_W-1:0]   mem_q [FRAME_DEPTH];

`ifdef RX_FRAME_SECOND_STAMP_EN
    assign rec_in = {sec_q, byte_cnt_q, ms_q, acc_q};
`else
    assign rec_in = {byte_cnt_q, ms_q, acc_q};
`endif

    // Extra MSB on the pointers separates full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign pop_en  = !n_rd_frame_fifo_i && !fifo_empty && n_Clr_i;
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts the record (it lands in the slot being vacated).
    assign push_en = push_req && (!fifo_full || pop_en);
    assign drop    = push_req && fifo_full && !pop_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            over_q   <= 1'b0;
        end else if (!n_Clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            over_q   <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                over_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= rec_in;
        end
    end

    assign head              = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign frame_info_o      = fifo_empty ? 28'd0 : head[27:0];
`ifdef RX_FRAME_SECOND_STAMP_EN
    assign frame_second_o    = fifo_empty ? 32'd0 : head[c_REC_W-1:28];
`endif
    assign p_RxFrame_Empty_o = fifo_empty;
    assign p_RxFrame_Full_o  = fifo_full;
    assign p_FrameOver_o     = over_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_tracker
// Description : Self-checking bench for rx_frame_tracker. Expected frame
//               records are queued as frames are closed and compared as the
//               host pops the frame-info FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_tracker;

    localparam int FRAME_DEPTH = 8;
    localparam int PTR_W       = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_Enable_i, p_FrameFunctionEnable_i;
    logic        BaudSig_i, p_DataReceived_i;
    logic [15:0] RxTimeOutSet_i;
    logic [3:0]  acqurate_stamp_i;
    logic [11:0] millisecond_stamp_i;
    logic        n_Clr_i, n_rd_frame_fifo_i;
    logic [27:0] frame_info_o;
    logic        p_RxFrame_Empty_o, p_RxFrame_Full_o, p_FrameOver_o, p_FrameEnd_o;
`ifdef RX_FRAME_SECOND_STAMP_EN
    logic [31:0] second_stamp_i = '0;
    logic [31:0] frame_second_o;
`endif

    always #5 clk = ~clk;

    rx_frame_tracker #(.FRAME_DEPTH(FRAME_DEPTH), .PTR_W(PTR_W)) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .p_Enable_i              (p_Enable_i),
        .p_FrameFunctionEnable_i (p_FrameFunctionEnable_i),
        .BaudSig_i               (BaudSig_i),
        .p_DataReceived_i        (p_DataReceived_i),
        .RxTimeOutSet_i          (RxTimeOutSet_i),
        .acqurate_stamp_i        (acqurate_stamp_i),
        .millisecond_stamp_i     (millisecond_stamp_i),
`ifdef RX_FRAME_SECOND_STAMP_EN
        .second_stamp_i          (second_stamp_i),
        .frame_second_o          (frame_second_o),
`endif
        .n_Clr_i                 (n_Clr_i),
        .n_rd_frame_fifo_i       (n_rd_frame_fifo_i),
        .frame_info_o            (frame_info_o),
        .p_RxFrame_Empty_o       (p_RxFrame_Empty_o),
        .p_RxFrame_Full_o        (p_RxFrame_Full_o),
        .p_FrameOver_o           (p_FrameOver_o),
        .p_FrameEnd_o            (p_FrameEnd_o)
    );

    int num_checks = 0;
    int num_errors = 0;
    int fe_count   = 0;

    // Scoreboard and reference model state
    logic [27:0] exp_q[$];
    int          mdl_cnt   = 0;
    bit          mdl_open  = 0;
    logic [11:0] mdl_bytes = '0;
    logic [11:0] mdl_ms    = '0;
    logic [3:0]  mdl_acc   = '0;

    always @(negedge clk) begin
        if (p_FrameEnd_o) fe_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit with_baud);
        millisecond_stamp_i = 12'($urandom_range(999));
        acqurate_stamp_i    = 4'($urandom_range(9));
        p_DataReceived_i    = 1'b1;
        BaudSig_i           = with_baud;
        if (!mdl_open) begin
            mdl_open  = 1;
            mdl_bytes = 12'd1;
        end else if (mdl_bytes != 12'hFFF) begin
            mdl_bytes = mdl_bytes + 12'd1;
        end
        mdl_ms  = millisecond_stamp_i;
        mdl_acc = acqurate_stamp_i;
        cyc();
        p_DataReceived_i = 1'b0;
        BaudSig_i        = 1'b0;
    endtask

    task automatic baud_tick();
        BaudSig_i = 1'b1;
        cyc();
        BaudSig_i = 1'b0;
    endtask

    // Idle ticks up to the timeout, then the CLOSE cycle (optionally with a pop).
    task automatic close_frame(input int ticks, input bit do_pop);
        logic [27:0] head;
        for (int i = 0; i < ticks; i++) baud_tick();
        check_val("frame_end_pulse", p_FrameEnd_o, 1);
        if (do_pop) begin
            head = exp_q.pop_front();
            check_val("head_at_close_pop", frame_info_o, head);
            mdl_cnt--;
            n_rd_frame_fifo_i = 1'b0;
        end
        if (mdl_cnt < FRAME_DEPTH) begin
            exp_q.push_back({mdl_bytes, mdl_ms, mdl_acc});
            mdl_cnt++;
        end
        mdl_open = 0;
        cyc();
        n_rd_frame_fifo_i = 1'b1;
    endtask

    task automatic pop_one();
        logic [27:0] head;
        head = exp_q.pop_front();
        check_val("pop_head", frame_info_o, head);
        mdl_cnt--;
        n_rd_frame_fifo_i = 1'b0;
        cyc();
        n_rd_frame_fifo_i = 1'b1;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) pop_one();
        check_val("drained_empty", p_RxFrame_Empty_o, 1);
        check_val("drained_info_zero", frame_info_o, 0);
    endtask

    task automatic one_byte_frame();
        send_byte(0);
        close_frame(3, 0);
    endtask

    int fe_base;

    initial begin
        rst = 1'b0;
        p_Enable_i = 1'b1; p_FrameFunctionEnable_i = 1'b1;
        BaudSig_i = 1'b0; p_DataReceived_i = 1'b0;
        RxTimeOutSet_i = 16'd3;
        acqurate_stamp_i = '0; millisecond_stamp_i = '0;
        n_Clr_i = 1'b1; n_rd_frame_fifo_i = 1'b1;
        repeat (3) cyc();

        // Reset state
        check_val("rst_info", frame_info_o, 0);
        check_val("rst_empty", p_RxFrame_Empty_o, 1);
        check_val("rst_full", p_RxFrame_Full_o, 0);
        check_val("rst_over", p_FrameOver_o, 0);
        check_val("rst_fe", p_FrameEnd_o, 0);
        rst = 1'b1;
        cyc();

        // Five bytes one baud apart, then timeout of three ticks
        fe_base = fe_count;
        for (int i = 0; i < 5; i++) begin
            send_byte(0);
            if (i < 4) baud_tick();
        end
        baud_tick(); baud_tick();
        check_val("no_early_close", p_FrameEnd_o, 0);
        close_frame(1, 0);
        check_val("one_frame_end", fe_count - fe_base, 1);
        check_val("not_empty_after_close", p_RxFrame_Empty_o, 0);
        drain();

        // Byte coincident with the timeout tick keeps the frame open
        for (int i = 0; i < 5; i++) send_byte(0);
        baud_tick(); baud_tick();
        fe_base = fe_count;
        send_byte(1);
        cyc();
        check_val("coincident_no_close", fe_count - fe_base, 0);
        close_frame(3, 0);
        check_val("six_bytes", frame_info_o[27:16], 6);
        drain();

        // Nine frames into an eight-deep FIFO
        for (int f = 1; f <= 9; f++) begin
            one_byte_frame();
            if (f == 7) check_val("full_after_7", p_RxFrame_Full_o, 0);
            if (f == 8) begin
                check_val("full_after_8", p_RxFrame_Full_o, 1);
                check_val("over_after_8", p_FrameOver_o, 0);
            end
        end
        check_val("over_after_9", p_FrameOver_o, 1);
        check_val("full_after_9", p_RxFrame_Full_o, 1);
        drain();
        check_val("over_sticky", p_FrameOver_o, 1);
        n_Clr_i = 1'b0;
        cyc();
        n_Clr_i = 1'b1;
        check_val("over_cleared", p_FrameOver_o, 0);

        // Full FIFO with a pop in the CLOSE cycle
        for (int f = 0; f < 8; f++) one_byte_frame();
        send_byte(0);
        send_byte(0);
        close_frame(3, 1);
        check_val("pop_close_over", p_FrameOver_o, 0);
        check_val("pop_close_full", p_RxFrame_Full_o, 1);
        drain();

        // No timeout: frame never closes; disabling aborts it silently
        RxTimeOutSet_i = 16'd0;
        fe_base = fe_count;
        for (int i = 0; i < 20; i++) send_byte(0);
        for (int i = 0; i < 100; i++) baud_tick();
        check_val("no_timeout_fe", fe_count - fe_base, 0);
        p_Enable_i = 1'b0;
        repeat (4) baud_tick();
        check_val("disabled_fe", fe_count - fe_base, 0);
        check_val("disabled_empty", p_RxFrame_Empty_o, 1);
        p_Enable_i = 1'b1;
        mdl_open = 0;
        RxTimeOutSet_i = 16'd3;
        repeat (2) baud_tick();
        check_val("reenable_empty", p_RxFrame_Empty_o, 1);

        // Asynchronous reset in the middle of a frame
        one_byte_frame();
        for (int i = 0; i < 3; i++) send_byte(0);
        #2 rst = 1'b0;
        #1;
        check_val("midrst_info", frame_info_o, 0);
        check_val("midrst_empty", p_RxFrame_Empty_o, 1);
        check_val("midrst_full", p_RxFrame_Full_o, 0);
        check_val("midrst_over", p_FrameOver_o, 0);
        check_val("midrst_fe", p_FrameEnd_o, 0);
        exp_q.delete();
        mdl_cnt = 0;
        mdl_open = 0;
        cyc();
        rst = 1'b1;
        cyc();
        send_byte(0);
        send_byte(0);
        close_frame(3, 0);
        check_val("after_rst_count", frame_info_o[27:16], 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_frame_tracker.md
Name: rx_frame_tracker

Overview:
- Sits directly downstream of the receive core's byte path.
- Consumes the per-byte "data received" pulse and the baud tick, and groups received bytes into frames using a programmable idle timeout measured in bit times.
- On each frame close, pushes a 28-bit frame record into a small internal frame-info FIFO: byte count plus the timestamp of the last byte.
- The host drains this FIFO through the frame-info read strobe.

Parameters:
- FRAME_DEPTH, 8, number of entries in the frame-info FIFO (power of 2, 2..64).
- PTR_W, 3, pointer width, log2(FRAME_DEPTH).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- p_Enable_i  input  1  block enable; low aborts any open frame.
- p_FrameFunctionEnable_i  input  1  frame grouping enable.
- BaudSig_i  input  1  one-clk pulse per bit time.
- p_DataReceived_i  input  1  one-clk pulse per byte accepted by the rx core.
- RxTimeOutSet_i  input  16  idle gap, in bit times, that closes a frame.
- acqurate_stamp_i  input  4  0.1 ms stamp, 0..9.
- millisecond_stamp_i  input  12  ms stamp, 0..999.
- n_Clr_i  input  1  synchronous clear, active low.
- n_rd_frame_fifo_i  input  1  frame-info pop, active low, 1 clk wide.
- frame_info_o  output  28  head record {byte_cnt[11:0], ms[11:0], acc[3:0]}.
- p_RxFrame_Empty_o  output  1  frame FIFO empty.
- p_RxFrame_Full_o  output  1  frame FIFO full.
- p_FrameOver_o  output  1  sticky: a frame was dropped because the FIFO was full.
- p_FrameEnd_o  output  1  one-clk pulse when a frame closes.

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE; byte counter, idle counter, latched stamps and pointers at 0.
  - frame_info_o = 0, p_RxFrame_Empty_o = 1, p_RxFrame_Full_o = 0, p_FrameOver_o = 0, p_FrameEnd_o = 0.
- Active condition: the FSM advances only when p_Enable_i = 1 and p_FrameFunctionEnable_i = 1. Otherwise the FSM is forced to IDLE, counters clear, no push occurs, and FIFO contents are kept.
- FSM states: IDLE, RECEIVING, CLOSE.
- IDLE -> RECEIVING on p_DataReceived_i:
  - byte_cnt = 1, idle_cnt = 0.
  - ms and acc are latched from the stamp inputs in that same cycle.
- In RECEIVING, each p_DataReceived_i:
  - byte_cnt += 1, saturating at 12'hFFF.
  - idle_cnt = 0; stamps re-latched.
- In RECEIVING, each BaudSig_i without a byte pulse increments idle_cnt (16 bit).
- RECEIVING -> CLOSE when a BaudSig_i pulse makes idle_cnt equal RxTimeOutSet_i.
- RxTimeOutSet_i = 0 means no timeout: the frame stays open.
- A byte pulse and a baud pulse in the same cycle: the byte wins, idle_cnt = 0, no close.
- CLOSE lasts exactly one clk:
  - p_FrameEnd_o = 1.
  - Record is written to the FIFO if not full; otherwise it is dropped and p_FrameOver_o is set.
  - Next state IDLE; byte_cnt and idle_cnt clear.
  - A p_DataReceived_i in the CLOSE cycle starts a new frame: next state RECEIVING, byte_cnt = 1.
- Latency: close is detected at BaudSig_i edge N. p_FrameEnd_o is high in cycle N+1. The record is visible on frame_info_o and p_RxFrame_Empty_o falls in cycle N+2.
- FIFO:
  - First-word fall-through: frame_info_o always shows the head entry, and shows 0 when empty.
  - A pop on n_rd_frame_fifo_i low advances the head at the next edge. A pop while empty is ignored.
  - Push and pop in the same cycle are both performed. When full, a simultaneous pop frees the slot, so the push succeeds and no overflow is flagged.
  - Pointers wrap modulo FRAME_DEPTH; an extra pointer bit distinguishes full from empty.
- n_Clr_i low:
  - pointers cleared, p_FrameOver_o cleared, FSM forced to IDLE.
  - Clear has priority over push and pop in the same cycle.
- Reset mid-frame discards the open frame; no record is pushed.

Optional Feature:
- Macro RX_FRAME_SECOND_STAMP_EN.
- Defined:
  - adds input second_stamp_i[31:0] and output frame_second_o[31:0].
  - the second stamp is latched alongside ms/acc and stored per FIFO entry.
  - frame_second_o shows the head entry's second stamp, 0 when empty.
- Undefined: those ports and that storage do not exist; all other behaviour is identical.

Test Plan:
- RxTimeOutSet_i = 3, 5 byte pulses spaced 1 baud apart, then 3 idle baud ticks -> one p_FrameEnd_o pulse; frame_info_o byte_cnt = 5, ms/acc equal the stamps present at the 5th byte; p_RxFrame_Empty_o = 0.
- Byte pulse coincident with the 3rd idle baud tick (RxTimeOutSet_i = 3) -> no close; byte_cnt continues to 6.
- 9 frames pushed into FRAME_DEPTH = 8 with no reads -> p_RxFrame_Full_o = 1 after the 8th, p_FrameOver_o = 1 after the 9th; the 9th record is lost and the first 8 read back in order.
- FIFO full, and a pop in the same cycle as a CLOSE -> no overflow; the FIFO stays full with the new record at the tail.
- RxTimeOutSet_i = 0, 20 bytes, then 100 idle ticks -> no frame end; drop p_Enable_i -> no record pushed and the FIFO stays empty.
- rst asserted mid-frame after 3 bytes -> all outputs at reset values; the next frame counts from 1.
